note_sequencer: RTL and testbench

- Plays a stored melody by driving the 27-bit note-select input of the note decoder. The decoder's 8-bit audio output is not connected to this block.
- Holds a small song table of (note, duration) entries, loaded through a write port. Steps through the table at a fixed tempo.
- Inserts a short rest between entries so that repeated notes retrigger.
- Supports start, stop and optional looping. Sits between the control logic / host writes and the note decoder.

---
 rtl/note_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song-table sequencer driving the note decoder's 27-bit select input.
// Optional looping is enabled by defining NOTE_SEQUENCER_LOOP_EN.
module note_sequencer #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned AW             = 4,
    parameter int unsigned DUR_W          = 4,
    parameter int unsigned TICKS_PER_BEAT = 1000,
    parameter int unsigned GAP_TICKS      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [6:0]       wr_note,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW:0]      length,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic [26:0]      note,
    output logic             busy,
    output logic [AW-1:0]    step_idx,
    output logic             beat,
    output logic             done
);

    localparam int unsigned LEN_W     = AW + 1;
    localparam int unsigned TICK_W    = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int unsigned GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned TICK_LAST = TICKS_PER_BEAT - 1;
    localparam int unsigned GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [6:0]       mem_note [DEPTH];
    logic [DUR_W-1:0] mem_dur  [DEPTH];

    logic [2:0]       state, state_nx;
    logic [TICK_W-1:0] tick_cnt, tick_nx;
    logic [DUR_W-1:0] beats_left, beats_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic [AW-1:0]    idx_nx;
    logic [6:0]       note_r, note_nx;
    logic             beat_nx, busy_nx, done_nx;
    logic             advance;
    logic             loop_eff;
    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] idx_inc;
    logic [DUR_W-1:0] load_dur;

`ifdef NOTE_SEQUENCER_LOOP_EN
    assign loop_eff = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_eff    = 1'b0;
`endif

    assign len_c    = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
    assign idx_inc  = LEN_W'(step_idx) + LEN_W'(1);
    assign load_dur = (mem_dur[step_idx] == '0) ? DUR_W'(1) : mem_dur[step_idx];
    assign note     = {20'b0, note_r};

    // Song table: write port only, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_note[wr_addr] <= wr_note;
            mem_dur[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            beats_left <= '0;
            gap_cnt    <= '0;
            step_idx   <= '0;
            note_r     <= '0;
            beat       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            tick_cnt   <= tick_nx;
            beats_left <= beats_nx;
            gap_cnt    <= gap_nx;
            step_idx   <= idx_nx;
            note_r     <= note_nx;
            beat       <= beat_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        beats_nx = beats_left;
        gap_nx   = gap_cnt;
        idx_nx   = step_idx;
        note_nx  = note_r;
        advance  = 1'b0;

        case (state)
            S_IDLE: begin
                note_nx = '0;
                if (start) begin
                    if (len_c != '0) begin
                        idx_nx   = '0;
                        state_nx = S_LOAD;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            // The table read lands directly in the note register
            S_LOAD: begin
                note_nx  = mem_note[step_idx];
                beats_nx = load_dur;
                tick_nx  = '0;
                state_nx = S_PLAY;
            end
            S_PLAY: begin
                if (tick_cnt == TICK_W'(TICK_LAST)) begin
                    tick_nx = '0;
                    if (beats_left <= DUR_W'(1)) begin
                        note_nx = '0;
                        if (GAP_TICKS == 0) begin
                            advance = 1'b1;
                        end else begin
                            gap_nx   = '0;
                            state_nx = S_GAP;
                        end
                    end else begin
                        beats_nx = beats_left - DUR_W'(1);
                    end
                end else begin
                    tick_nx = tick_cnt + TICK_W'(1);
                end
            end
            S_GAP: begin
                note_nx = '0;
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    advance = 1'b1;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            S_DONE: begin
                note_nx  = '0;
                state_nx = S_IDLE;
            end
            default: begin
                note_nx  = '0;
                state_nx = S_IDLE;
            end
        endcase

        // length is compared as step_idx+1 so a shrink to 0 cannot underflow
        if (advance) begin
            if (idx_inc < len_c) begin
                idx_nx   = AW'(idx_inc);
                state_nx = S_LOAD;
            end else if (loop_eff && (len_c != '0)) begin
                idx_nx   = '0;
                state_nx = S_LOAD;
            end else begin
                state_nx = S_DONE;
            end
        end

        if (stop && (state != S_IDLE)) begin
            note_nx  = '0;
            state_nx = S_IDLE;
        end

        beat_nx = (state_nx == S_PLAY) && (tick_nx == TICK_W'(TICK_LAST));
        busy_nx = (state_nx == S_LOAD) || (state_nx == S_PLAY) || (state_nx == S_GAP);
        done_nx = (state_nx == S_DONE);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICKS_PER_BEAT=4, GAP_TICKS=2.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [6:0]  wr_note;
    logic [3:0]  wr_dur;
    logic [4:0]  length;
    logic        start;
    logic        stop;
    logic        loop;
    logic [26:0] note;
    logic        busy;
    logic [3:0]  step_idx;
    logic        beat;
    logic        done;

    int checks = 0;
    int errors = 0;
    int k = 0;

    note_sequencer #(
        .DEPTH(16), .AW(4), .DUR_W(4), .TICKS_PER_BEAT(4), .GAP_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_note(wr_note), .wr_dur(wr_dur), .length(length), .start(start),
        .stop(stop), .loop(loop), .note(note), .busy(busy),
        .step_idx(step_idx), .beat(beat), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {2'b0, note, busy, beat, done};
    endfunction

    function automatic logic [31:0] pk(input logic [6:0] n, input logic b, input logic bt, input logic d);
        return {2'b0, 20'b0, n, b, bt, d};
    endfunction

    // Hand schedule for entries 0:(88,1), 1:(n1,2), length 2, k = cycles after start
    function automatic logic [31:0] exp_song(input int kk, input logic [6:0] n1);
        logic [6:0] n;
        logic b, bt, d;
        n = 7'd0; b = 1'b1; bt = 1'b0; d = 1'b0;
        if (kk >= 2 && kk <= 5)  n = 7'd88;
        if (kk >= 9 && kk <= 16) n = n1;
        if (kk == 5 || kk == 12 || kk == 16) bt = 1'b1;
        if (kk >= 19) b = 1'b0;
        if (kk == 19) d = 1'b1;
        return pk(n, b, bt, d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        k++;
    endtask

    task automatic kick();
        start = 1'b1;
        k = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] n, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Full two-entry song; with hook, rewrite entry 1 and retry start mid entry 0
    task automatic play_song(input string nm, input logic [6:0] n1, input bit hook);
        kick();
        while (k <= 20) begin
            check($sformatf("%s k=%0d", nm, k), obs(), exp_song(k, n1));
            if (k == 1) check($sformatf("%s idx0", nm), 32'(step_idx), 32'd0);
            if (k == 8) check($sformatf("%s idx1", nm), 32'(step_idx), 32'd1);
            if (hook && k == 3) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_note = 7'd99; wr_dur = 4'd2;
                start = 1'b1;
                step();
                wr_en = 1'b0; start = 1'b0;
                check($sformatf("%s busy-start idx", nm), 32'(step_idx), 32'd0);
            end else begin
                step();
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_dur = '0;
        length = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick(); tick();
        check("reset outs", obs(), 32'd0);
        check("reset idx", 32'(step_idx), 32'd0);
        reset = 1'b0;

        wr(4'd0, 7'd88, 4'd1);
        wr(4'd1, 7'd1, 4'd2);
        length = 5'd2;
        tick();
        play_song("song", 7'd1, 1'b0);

        // Zero duration plays as one beat
        wr(4'd0, 7'd60, 4'd0);
        length = 5'd1;
        kick();
        while (k <= 9) begin
            case (k)
                2: check("dur0 first", obs(), pk(7'd60, 1, 0, 0));
                5: check("dur0 last", obs(), pk(7'd60, 1, 1, 0));
                6: check("dur0 gap", obs(), pk(7'd0, 1, 0, 0));
                8: check("dur0 done", obs(), pk(7'd0, 0, 0, 1));
                9: check("dur0 idle", obs(), pk(7'd0, 0, 0, 0));
                default: ;
            endcase
            step();
        end
        wr(4'd0, 7'd88, 4'd1);

        // Empty song: immediate done, never audible
        length = 5'd0;
        kick();
        check("len0 done", obs(), pk(7'd0, 0, 0, 1));
        step();
        check("len0 idle", obs(), pk(7'd0, 0, 0, 0));

        // Stop with a simultaneous start in the 2nd cycle of entry 1
        length = 5'd2;
        kick();
        while (k < 10) step();
        check("pre-stop", obs(), pk(7'd1, 1, 0, 0));
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("stop outs", obs(), pk(7'd0, 0, 0, 0));
        check("stop idx", 32'(step_idx), 32'd1);
        step(); step();
        check("stop no done", obs(), pk(7'd0, 0, 0, 0));

        play_song("rewrite", 7'd99, 1'b1);

        // Loop request at the end of the last entry
        loop = 1'b1;
        kick();
        while (k < 19) step();
`ifdef NOTE_SEQUENCER_LOOP_EN
        check("loop reload", obs(), pk(7'd0, 1, 0, 0));
        check("loop idx", 32'(step_idx), 32'd0);
        step();
        check("loop replay", obs(), pk(7'd88, 1, 0, 0));
`else
        check("noloop done", obs(), pk(7'd0, 0, 0, 1));
        step();
        check("noloop idle", obs(), pk(7'd0, 0, 0, 0));
`endif
        stop = 1'b1; loop = 1'b0;
        tick();
        stop = 1'b0;
        tick();

        // Reset mid-play keeps the table
        kick();
        while (k < 4) step();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset outs", obs(), pk(7'd0, 0, 0, 0));
        check("midreset idx", 32'(step_idx), 32'd0);
        tick();
        play_song("after reset", 7'd99, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
